ad_float_feeder: RTL

- Sits between the ad7606 sample FIFO and the short_to_float converter.
- Waits until a full frame of CH_NUM samples is buffered, then reads it from the FIFO as one atomic burst and drives the samples into short_to_float.
- Tracks the converter's fixed pipeline latency with a tag shift register.
- Outputs each float result with its channel index, plus start-of-frame and frame-done strobes.

---
 rtl/ad_float_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ad_float_feeder.sv
// Frame-atomic reader between the AD7606 sample FIFO and short_to_float; tags each sample through the converter latency.
// Build option: define AD_OFFSET_BIN_EN to treat fifo_q as offset-binary (bit 15 inverted before the converter).
module ad_float_feeder #(
    parameter int CH_NUM   = 8,
    parameter int CONV_LAT = 6,
    parameter int USEDW_W  = 6,
    parameter int CH_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    output logic               fifo_rdreq,
    input  logic [15:0]        fifo_q,
    output logic [15:0]        cvt_dataa,
    input  logic [31:0]        cvt_result,
    output logic               out_valid,
    output logic [31:0]        out_data,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_sof,
    output logic               frame_done,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BURST  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    // Stage 0 is loaded in the rdreq cycle; the last stage lines up with the registered result.
    localparam int                TAG_N       = CONV_LAT + 3;
    localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(CH_NUM - 1);
    localparam logic [USEDW_W:0]  FRAME_WORDS = (USEDW_W + 1)'(CH_NUM);

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic            sof;
        logic            last;
    } tag_t;

    logic [1:0]      r_state;
    logic [CH_W-1:0] r_rd_ch;
    logic            r_settle_cnt;
    logic            r_rd_valid;
    logic [15:0]     r_cvt_dataa;
    logic [31:0]     r_out_data;
    tag_t            r_tag [TAG_N];

    logic            w_burst;
    logic            w_start;
    logic [15:0]     w_stage_in;
    tag_t            w_tag_in;

    assign w_burst = (r_state == S_BURST);
    assign w_start = en && ({1'b0, fifo_rdusedw} >= FRAME_WORDS);

`ifdef AD_OFFSET_BIN_EN
    assign w_stage_in = {~fifo_q[15], fifo_q[14:0]};
`else
    assign w_stage_in = fifo_q;
`endif

    // NOTE: every field gets a value on every path, so no latch can be inferred.
    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_burst;
        if (w_burst) begin
            w_tag_in.ch   = r_rd_ch;
            w_tag_in.sof  = (r_rd_ch == '0);
            w_tag_in.last = (r_rd_ch == LAST_CH);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_ch      <= '0;
            r_settle_cnt <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_BURST;
                        r_rd_ch <= '0;
                    end
                end
                S_BURST: begin
                    if (r_rd_ch == LAST_CH) begin
                        r_state      <= S_SETTLE;
                        r_rd_ch      <= '0;
                        r_settle_cnt <= 1'b0;
                    end else begin
                        r_rd_ch <= r_rd_ch + CH_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt) r_state <= S_IDLE;
                    else              r_settle_cnt <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Staging register doubles as the converter operand; it holds when no sample arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_cvt_dataa <= '0;
        end else begin
            r_rd_valid <= w_burst;
            if (r_rd_valid) r_cvt_dataa <= w_stage_in;
        end
    end

    // NOTE: the tag shift register is reset on purpose so a reset flushes every in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAG_N; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < TAG_N; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_out_data <= '0;
        else if (r_tag[TAG_N-2].valid) r_out_data <= cvt_result;
    end

    assign fifo_rdreq = w_burst;
    assign busy       = (r_state != S_IDLE);
    assign cvt_dataa  = r_cvt_dataa;
    assign out_data   = r_out_data;
    assign out_valid  = r_tag[TAG_N-1].valid;
    assign out_ch     = r_tag[TAG_N-1].ch;
    assign out_sof    = r_tag[TAG_N-1].sof;
    assign frame_done = r_tag[TAG_N-1].last;

endmodule
